// File: rtl/seq_chunk_adder_if.sv
// Start/done handshake bundle for the chunked adder/subtractor.
// The datapath side is the master; the adder is the slave.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, cin, in1, in2,
        input  out, carry, overflow, zero, busy, done
    );

    modport slave (
        input  start, sub, cin, in1, in2,
        output out, carry, overflow, zero, busy, done
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: a CHUNK-bit core processes one slice per clock,
// with the carry rippling between slices through a register.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic          clk,
    input logic          reset,
    seq_chunk_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLAST = KW'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             c;
    logic [KW-1:0]    k;
    logic [CHUNK:0]   chunk_sum;
    logic             last;

    logic [WIDTH-1:0] out_r;
    logic             carry_r;
    logic             overflow_r;
    logic             zero_r;
    logic             busy_r;
    logic             done_r;

    // Narrow core: one slice of A plus the matching slice of the effective B.
    always_comb begin
        chunk_sum = {1'b0, a[k*CHUNK +: CHUNK]} + {1'b0, b[k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, c};
        acc_next = acc;
        acc_next[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        last = (k == KLAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Subtraction is folded into the operand latch as A + ~B + ~borrow.
    always_ff @(posedge clk) begin
        if (reset) begin
            a          <= '0;
            b          <= '0;
            acc        <= '0;
            c          <= 1'b0;
            k          <= '0;
            out_r      <= '0;
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    a      <= bus.in1;
                    b      <= bus.sub ? ~bus.in2 : bus.in2;
                    c      <= bus.sub ? ~bus.cin : bus.cin;
                    acc    <= '0;
                    k      <= '0;
                    busy_r <= 1'b1;
                end
            end else begin
                acc <= acc_next;
                c   <= chunk_sum[CHUNK];
                k   <= k + 1'b1;
                if (last) begin
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                    out_r      <= acc_next;
                    carry_r    <= chunk_sum[CHUNK];
                    overflow_r <= (a[WIDTH-1] == b[WIDTH-1]) &&
                                  (acc_next[WIDTH-1] != a[WIDTH-1]);
                    zero_r     <= (acc_next == '0);
                end
            end
        end
    end

    assign bus.out      = out_r;
    assign bus.carry    = carry_r;
    assign bus.overflow = overflow_r;
    assign bus.zero     = zero_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed and model-checked bench for seq_chunk_adder in three width/chunk
// configurations: 32/8, 32/32 and 16/4.
module tb_seq_chunk_adder;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(32)) if0 ();
    seq_chunk_adder_if #(.WIDTH(32)) if1 ();
    seq_chunk_adder_if #(.WIDTH(16)) if2 ();

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8))  dut0 (.clk(clk), .reset(reset), .bus(if0));
    seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  dut2 (.clk(clk), .reset(reset), .bus(if2));

    int total = 0;
    int bad   = 0;

    logic [31:0] outv  [3];
    logic        carv  [3];
    logic        ovfv  [3];
    logic        zerv  [3];
    logic        busyv [3];
    logic        donev [3];
    logic [31:0] lastOut [3];
    int          lat [3] = '{5, 2, 5};
    int          wid [3] = '{32, 32, 16};

    assign outv[0]  = if0.out;
    assign outv[1]  = if1.out;
    assign outv[2]  = {16'h0000, if2.out};
    assign carv[0]  = if0.carry;
    assign carv[1]  = if1.carry;
    assign carv[2]  = if2.carry;
    assign ovfv[0]  = if0.overflow;
    assign ovfv[1]  = if1.overflow;
    assign ovfv[2]  = if2.overflow;
    assign zerv[0]  = if0.zero;
    assign zerv[1]  = if1.zero;
    assign zerv[2]  = if2.zero;
    assign busyv[0] = if0.busy;
    assign busyv[1] = if1.busy;
    assign busyv[2] = if2.busy;
    assign donev[0] = if0.done;
    assign donev[1] = if1.done;
    assign donev[2] = if2.done;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic driveInputs(input int cfg, input logic st, input logic s, input logic c,
                               input logic [31:0] a, input logic [31:0] b);
        case (cfg)
            0: begin if0.start = st; if0.sub = s; if0.cin = c; if0.in1 = a; if0.in2 = b; end
            1: begin if1.start = st; if1.sub = s; if1.cin = c; if1.in1 = a; if1.in2 = b; end
            2: begin
                if2.start = st; if2.sub = s; if2.cin = c;
                if2.in1 = a[15:0]; if2.in2 = b[15:0];
            end
            default: ;
        endcase
    endtask

    // Whole-width reference arithmetic: in1 + (sub ? ~in2 : in2) + (sub ? ~cin : cin).
    task automatic refModel(input int w, input logic s, input logic c,
                            input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] o, output logic co,
                            output logic v, output logic z);
        logic [31:0] mask;
        logic [31:0] am;
        logic [31:0] beff;
        logic [32:0] sum;
        logic        ci;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        am   = a & mask;
        beff = (s ? ~b : b) & mask;
        ci   = s ? ~c : c;
        sum  = {1'b0, am} + {1'b0, beff} + {32'd0, ci};
        o    = sum[31:0] & mask;
        co   = sum[w];
        v    = (am[w-1] == beff[w-1]) && (o[w-1] != am[w-1]);
        z    = (o == 32'd0);
    endtask

    // Called at a negedge; start is raised now and sampled at the next edge.
    task automatic applyStimulus(input string tag, input int cfg, input logic s, input logic c,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] eo, input logic ec, input logic ev,
                                 input logic ez, input bit disturb);
        int i;
        int busyCnt;
        bit seen;
        i       = 0;
        busyCnt = 0;
        seen    = 1'b0;
        driveInputs(cfg, 1'b1, s, c, a, b);
        while (!seen && i < 20) begin
            @(negedge clk);
            i++;
            if (i == 1) driveInputs(cfg, 1'b0, s, c, a, b);
            if (disturb && i == 2) driveInputs(cfg, 1'b1, ~s, ~c, ~a, ~b);
            if (disturb && i == 3) driveInputs(cfg, 1'b0, ~s, ~c, ~a, ~b);
            if (i == 2 && lat[cfg] > 2)
                checkOutput({tag, "/hold"}, outv[cfg], lastOut[cfg]);
            if (donev[cfg]) seen = 1'b1;
            else if (busyv[cfg]) busyCnt++;
        end
        checkOutput({tag, "/latency"}, i, lat[cfg]);
        checkOutput({tag, "/busycycles"}, busyCnt, lat[cfg] - 1);
        checkOutput({tag, "/busy_at_done"}, {31'd0, busyv[cfg]}, 32'd0);
        checkOutput({tag, "/out"}, outv[cfg], eo);
        checkOutput({tag, "/carry"}, {31'd0, carv[cfg]}, {31'd0, ec});
        checkOutput({tag, "/overflow"}, {31'd0, ovfv[cfg]}, {31'd0, ev});
        checkOutput({tag, "/zero"}, {31'd0, zerv[cfg]}, {31'd0, ez});
        lastOut[cfg] = eo;
    endtask

    task automatic idleCheck(input string tag, input int cfg);
        @(negedge clk);
        checkOutput({tag, "/nodone"}, {31'd0, donev[cfg]}, 32'd0);
        checkOutput({tag, "/outhold"}, outv[cfg], lastOut[cfg]);
    endtask

    task automatic applyModel(input string tag, input int cfg, input logic s, input logic c,
                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] o;
        logic co, v, z;
        refModel(wid[cfg], s, c, a, b, o, co, v, z);
        applyStimulus(tag, cfg, s, c, a, b, o, co, v, z, 1'b0);
        idleCheck(tag, cfg);
    endtask

    initial begin
        bit sawDone;
        reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
            driveInputs(j, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            lastOut[j] = 32'd0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("rst/out", outv[0], 32'd0);
        checkOutput("rst/busy", {31'd0, busyv[0]}, 32'd0);
        checkOutput("rst/done", {31'd0, donev[0]}, 32'd0);
        checkOutput("rst/carry", {31'd0, carv[0]}, 32'd0);
        checkOutput("rst/zero", {31'd0, zerv[0]}, 32'd0);
        @(negedge clk);

        // Add with carry-out and overflow, then back-to-back start in the done cycle
        applyStimulus("t1", 0, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000,
                      32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus("t2a", 0, 1'b0, 1'b1, 32'h0000_8000, 32'h8000_0000,
                      32'h8000_8001, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCheck("t2a", 0);
        applyStimulus("t2b", 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000,
                      32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        idleCheck("t2b", 0);

        applyStimulus("t3a", 0, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007,
                      32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("t3b", 0, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001,
                      32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("t3c", 0, 1'b1, 1'b1, 32'h0000_0007, 32'h0000_0005,
                      32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCheck("t3c", 0);

        // Start pulse and operand changes while busy must be ignored
        applyStimulus("t4", 0, 1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111,
                      32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b1);
        idleCheck("t4a", 0);
        idleCheck("t4b", 0);

        // Reset sampled at the edge after E2 aborts the operation
        driveInputs(0, 1'b1, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001);
        @(negedge clk);
        driveInputs(0, 1'b0, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 3; j++) lastOut[j] = 32'd0;
        checkOutput("t5/busy", {31'd0, busyv[0]}, 32'd0);
        checkOutput("t5/done", {31'd0, donev[0]}, 32'd0);
        checkOutput("t5/out", outv[0], 32'd0);
        checkOutput("t5/carry", {31'd0, carv[0]}, 32'd0);
        checkOutput("t5/overflow", {31'd0, ovfv[0]}, 32'd0);
        checkOutput("t5/zero", {31'd0, zerv[0]}, 32'd0);
        sawDone = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (donev[0]) sawDone = 1'b1;
        end
        checkOutput("t5/nodone_after_abort", {31'd0, sawDone}, 32'd0);
        applyStimulus("t5/restart", 0, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001,
                      32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCheck("t5/restart", 0);

        // Single-chunk and 16/4 configurations, directed boundaries then random
        applyStimulus("t6/n1_ripple", 1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001,
                      32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        idleCheck("t6/n1_ripple", 1);
        applyStimulus("t6/w16_ovf", 2, 1'b0, 1'b0, 32'h0000_7FFF, 32'h0000_0001,
                      32'h0000_8000, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("t6/w16_ripple", 2, 1'b0, 1'b1, 32'h0000_FFFF, 32'h0000_0000,
                      32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        idleCheck("t6/w16_ripple", 2);
        for (int cfg = 0; cfg < 3; cfg++) begin
            for (int n = 0; n < 8; n++) begin
                applyModel($sformatf("t6/rand_c%0d_%0d", cfg, n), cfg,
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           $urandom, $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor, successor to the combinational 32-bit full adder.
- Adds or subtracts two WIDTH-bit operands with carry/borrow-in, processing CHUNK bits per clock and rippling the carry between chunks in a register.
- Trades latency for a narrow CHUNK-bit adder core.
- Operates as a start/done handshake slave in the datapath; also reports signed overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits processed per clock; N = WIDTH/CHUNK passes per operation (N >= 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = add, 1 = subtract; latched with operands.
- cin  input  1  carry-in for add, borrow-in for subtract; latched with operands.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- out  output  WIDTH  result; holds last completed value.
- carry  output  1  final carry-out of the internal adder (for sub: 1 = no borrow).
- overflow  output  1  signed two's-complement overflow of last result.
- zero  output  1  1 when the last result out == 0.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when out/carry/overflow/zero update.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset. When reset=1 at an edge: out=0, carry=0, overflow=0, zero=0, busy=0, done=0, state=IDLE, internal chunk index/accumulator cleared.
- States: IDLE, RUN.
  - In IDLE, start=1 at edge E0: latch A=in1, B_eff = sub ? ~in2 : in2, c = sub ? ~cin : cin. Then set chunk index k=0, busy=1, and go to RUN.
  - RUN, edges E1..EN: each edge computes {c, acc[k*CHUNK +: CHUNK]} = A chunk k + B_eff chunk k + c, then k increments.
  - At EN (last chunk): go to IDLE, busy=0, done=1. Commit out=acc, carry=c. Set overflow = (A[MSB]==B_eff[MSB]) && (acc[MSB]!=A[MSB]) and zero=(acc==0).
- Arithmetic:
  - Add: out = in1 + in2 + cin.
  - Sub: out = in1 - in2 - cin, computed as in1 + ~in2 + ~cin, all mod 2^WIDTH.
- Latency and handshake:
  - done is high exactly during the cycle after EN, i.e. N+1 edges after the start edge. For the defaults, N=4.
  - done is low in all other cycles.
  - busy is high for cycles after E0 through EN; it falls at EN, the same edge done rises.
- Back-to-back operation: start=1 in the done cycle (state IDLE) is accepted. A new operation can begin every N+1 cycles.
- start while busy=1 is ignored. in1/in2/sub/cin changes during RUN have no effect, because operands are latched.
- out, carry, overflow and zero change only at a completing edge (or reset); they hold otherwise, including throughout RUN.
- reset mid-RUN aborts the operation: no done pulse and outputs cleared as above. reset has priority over start in the same cycle.
- N=1 (CHUNK=WIDTH): single RUN cycle, done two edges after start.

Test Plan:
1. Add with carry-out and overflow (defaults): in1=8000_0000, in2=8000_0000, cin=0, sub=0, start pulse → after 5 edges done=1, out=0000_0000, carry=1, overflow=1, zero=1; busy high 4 cycles.
2. Back-to-back add: start in the done cycle of test 1 with in1=0000_8000, in2=8000_0000, cin=1 → out=8000_8001, carry=0, overflow=0, zero=0. Also FFFF_FFFF+0000_0000 with cin=1 → out=0, carry=1 (carry ripples across all 4 chunks).
3. Subtract: 0000_0005 − 0000_0007 with cin=0 → out=FFFF_FFFE, carry=0, overflow=0. Then 8000_0000 − 0000_0001 with cin=0 → out=7FFF_FFFF, carry=1, overflow=1. Then 0000_0007 − 0000_0005 with cin=1 → out=0000_0001, carry=1.
4. Handshake robustness: pulse start again and change in1/in2 during busy → ignored; result matches originally latched operands; exactly one done pulse.
5. Reset mid-op: assert reset at the edge after E2 → busy=0, done never pulses, all outputs 0. Next start completes normally.
6. Parameter sweep: WIDTH=32/CHUNK=32 (done 2 edges after start) and WIDTH=16/CHUNK=4 (done 5 edges after start). Random add/sub on each configuration is checked against a reference model of the arithmetic rules above.
